seg7_scan_ctrl: RTL and testbench

//  Time-multiplexes one shared active-low 7-segment bus (plus decimal point) across N_DIGITS

---
 rtl/seg7_pkg.sv | 48 ++++
 rtl/seg7_decode.sv | 14 +
 rtl/seg7_scan_ctrl.sv | 162 ++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants, scan-state encoding and glyph lookup for the 7-segment scan controller.
// Segment vectors are ordered [0:6] = a..g and are active-low (0 = segment lit).
package seg7_pkg;

    // All segments dark.
    localparam logic [0:6] SEG_OFF  = 7'h7F;

    // Only segment g lit; shown for non-decimal codes 10..15.
    localparam logic [0:6] SEG_DASH = 7'b1111110;

    // Glyphs for 0..9, written a..g from MSB to LSB.
    localparam logic [0:6] SEG_0 = 7'b0000001;
    localparam logic [0:6] SEG_1 = 7'b1001111;
    localparam logic [0:6] SEG_2 = 7'b0010010;
    localparam logic [0:6] SEG_3 = 7'b0000110;
    localparam logic [0:6] SEG_4 = 7'b1001100;
    localparam logic [0:6] SEG_5 = 7'b0100100;
    localparam logic [0:6] SEG_6 = 7'b0100000;
    localparam logic [0:6] SEG_7 = 7'b0001111;
    localparam logic [0:6] SEG_8 = 7'b0000000;
    localparam logic [0:6] SEG_9 = 7'b0000100;

    // Phase within a digit slot: blanking gap first, then the digit is driven.
    typedef enum logic {
        GAP  = 1'b0,
        SHOW = 1'b1
    } scan_state_e;

    // Map a 4-bit code to its active-low segment pattern.
    function automatic logic [0:6] seg_glyph(input logic [3:0] code);
        logic [0:6] seg;
        case (code)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low 7-segment decoder; codes 10..15 render as a dash.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [0:6] seg_o
);

    // Pure table lookup, no state.
    always_comb begin
        seg_o = seg_glyph(bcd_i);
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed common-anode 7-segment scan controller.
// Snapshots all digits once per frame, blanks for GAP_CYCLES at the start of
// every digit slot, and registers every pin (one cycle behind cnt/idx/snap).
// Optional build macro: LEADING_ZERO_BLANK_EN suppresses leading zero digits
// (digit 0 is always shown; a digit with its decimal point requested is shown).
// rst is asynchronous active-low; its deassertion must already be synchronous to clk.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int DIGIT_HZ   = 1_000,
    parameter int N_DIGITS   = 4,
    parameter int GAP_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [4*N_DIGITS-1:0]   digits_bcd,
    input  logic [N_DIGITS-1:0]     dp_in,
    output logic [N_DIGITS-1:0]     anode,
    output logic [0:6]              display,
    output logic                    dp,
    output logic                    frame_start
);

    localparam int DWELL = CLK_HZ / DIGIT_HZ;
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] CNT_GAP  = CNT_W'(GAP_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

    // Scan position and frame snapshot.
    logic [CNT_W-1:0]        cnt_q,     cnt_d;
    logic [IDX_W-1:0]        idx_q,     idx_d;
    logic [4*N_DIGITS-1:0]   snap_q,    snap_d;
    logic [N_DIGITS-1:0]     snap_dp_q, snap_dp_d;

    // Registered pin drivers.
    logic [N_DIGITS-1:0]     anode_q,       anode_d;
    logic [0:6]              display_q,     display_d;
    logic                    dp_q,          dp_d;
    logic                    frame_start_q, frame_start_d;

    // Current-slot view of the snapshot.
    scan_state_e             state;
    logic [3:0]              cur_bcd;
    logic                    cur_dp;
    logic                    cur_blank;
    logic [0:6]              cur_seg;
    logic [N_DIGITS-1:0]     blank_mask;

    // Slot phase follows directly from the position inside the dwell period.
    always_comb begin
        state = (cnt_q < CNT_GAP) ? GAP : SHOW;
    end

    // Select the snapshot nibble, decimal point and suppression flag of the active digit.
    always_comb begin
        cur_bcd   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_bcd   = snap_q[4*i +: 4];
                cur_dp    = snap_dp_q[i];
                cur_blank = blank_mask[i];
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Walk down from the most significant digit: a zero is leading while everything above it is zero.
    always_comb begin
        logic higher_zero;
        higher_zero = 1'b1;
        blank_mask  = '0;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            blank_mask[i] = (snap_q[4*i +: 4] == 4'h0) && higher_zero && !snap_dp_q[i];
            higher_zero   = higher_zero && (snap_q[4*i +: 4] == 4'h0);
        end
    end
`else
    // Every digit is always shown, leading zeros included.
    always_comb begin
        blank_mask = '0;
    end
`endif

    seg7_decode u_decode (
        .bcd_i (cur_bcd),
        .seg_o (cur_seg)
    );

    // Next-state for counters, snapshot and pins; outputs default to blank.
    always_comb begin
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        snap_d        = snap_q;
        snap_dp_d     = snap_dp_q;
        anode_d       = '1;
        display_d     = SEG_OFF;
        dp_d          = 1'b1;
        frame_start_d = 1'b0;

        if (!enable) begin
            // Disabled: park at the start of a frame so re-enable acts like reset release.
            cnt_d = '0;
            idx_d = '0;
        end else begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end

            // Latch the whole frame at its first cycle so digits never tear mid-frame.
            if (cnt_q == '0 && idx_q == '0) begin
                snap_d        = digits_bcd;
                snap_dp_d     = dp_in;
                frame_start_d = 1'b1;
            end

            if (state == SHOW && !cur_blank) begin
                anode_d   = ~(N_DIGITS'(1) << idx_q);
                display_d = cur_seg;
                dp_d      = ~cur_dp;
            end
        end
    end

    // State and pin registers; reset blanks the display immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            snap_q        <= '0;
            snap_dp_q     <= '0;
            anode_q       <= '1;
            display_q     <= SEG_OFF;
            dp_q          <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            snap_q        <= snap_d;
            snap_dp_q     <= snap_dp_d;
            anode_q       <= anode_d;
            display_q     <= display_d;
            dp_q          <= dp_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign anode       = anode_q;
    assign display     = display_q;
    assign dp          = dp_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl: DWELL=10, GAP_CYCLES=2, N_DIGITS=4 (40-cycle frame).
module tb_seg7_scan_ctrl;

    localparam int N = 4;

    // Hand-written active-low glyphs, a..g from MSB to LSB.
    localparam logic [6:0] G0 = 7'b0000001;
    localparam logic [6:0] G1 = 7'b1001111;
    localparam logic [6:0] G2 = 7'b0010010;
    localparam logic [6:0] G3 = 7'b0000110;
    localparam logic [6:0] G4 = 7'b1001100;
    localparam logic [6:0] G5 = 7'b0100100;
    localparam logic [6:0] G6 = 7'b0100000;
    localparam logic [6:0] G7 = 7'b0001111;
    localparam logic [6:0] G8 = 7'b0000000;
    localparam logic [6:0] G9 = 7'b0000100;
    localparam logic [6:0] GD = 7'b1111110;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [3:0] SH_00A0      = 4'b0011;
    localparam logic [3:0] SH_0050      = 4'b0011;
    localparam logic [3:0] SH_0050_DP2  = 4'b0111;
`else
    localparam logic [3:0] SH_00A0      = 4'b1111;
    localparam logic [3:0] SH_0050      = 4'b1111;
    localparam logic [3:0] SH_0050_DP2  = 4'b1111;
`endif

    typedef struct {
        logic [15:0]      digits;
        logic [3:0]       dpi;
        logic [15:0]      mid_digits;
        logic [3:0]       mid_dpi;
        logic [3:0][6:0]  seg;
        logic [3:0]       show;
    } vec_t;

    logic             clk;
    logic             rst;
    logic             enable;
    logic [4*N-1:0]   digits_bcd;
    logic [N-1:0]     dp_in;
    logic [N-1:0]     anode;
    logic [0:6]       display;
    logic             dp;
    logic             frame_start;

    int checks;
    int failures;

    vec_t vecs[7];

    seg7_scan_ctrl #(
        .CLK_HZ     (1000),
        .DIGIT_HZ   (100),
        .N_DIGITS   (N),
        .GAP_CYCLES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .digits_bcd  (digits_bcd),
        .dp_in       (dp_in),
        .anode       (anode),
        .display     (display),
        .dp          (dp),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    // Compare pins {anode, display, dp, frame_start} against an expected vector.
    task automatic check(input string name, input logic [12:0] exp);
        logic [12:0] act;
        act = {anode, display, dp, frame_start};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got an=%b seg=%b dp=%b fs=%b required an=%b seg=%b dp=%b fs=%b",
                     name, act[12:9], act[8:2], act[1], act[0],
                     exp[12:9], exp[8:2], exp[1], exp[0]);
        end
    endtask

    localparam logic [12:0] BLANK = {4'b1111, 7'h7F, 1'b1, 1'b0};

    // Run one 40-cycle frame starting at a negedge just before the snapshot edge.
    task automatic run_frame(input string tag, input vec_t v);
        int slot;
        int c;
        logic [12:0] exp;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            slot = k / 10;
            c    = k % 10;
            exp  = BLANK;
            if (c >= 2 && v.show[slot]) begin
                exp[12:9] = ~(4'b0001 << slot);
                exp[8:2]  = v.seg[slot];
                exp[1]    = ~v.dpi[slot];
            end
            exp[0] = (k == 0);
            check($sformatf("%s k%0d", tag, k), exp);
            if (k == 15) begin
                digits_bcd = v.mid_digits;
                dp_in      = v.mid_dpi;
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        vecs[0] = '{16'h4321, 4'b0000, 16'h4321, 4'b0000, {G4, G3, G2, G1}, 4'b1111};
        vecs[1] = '{16'h4321, 4'b0000, 16'h8765, 4'b0000, {G4, G3, G2, G1}, 4'b1111};
        vecs[2] = '{16'h8765, 4'b0000, 16'h8765, 4'b0000, {G8, G7, G6, G5}, 4'b1111};
        vecs[3] = '{16'h00A0, 4'b0010, 16'h00A0, 4'b0010, {G0, G0, GD, G0}, SH_00A0};
        vecs[4] = '{16'hFB09, 4'b1001, 16'hFB09, 4'b1001, {GD, GD, G0, G9}, 4'b1111};
        vecs[5] = '{16'h0050, 4'b0000, 16'h0050, 4'b0000, {G0, G0, G5, G0}, SH_0050};
        vecs[6] = '{16'h0050, 4'b0100, 16'h0050, 4'b0100, {G0, G0, G5, G0}, SH_0050_DP2};

        rst        = 1'b0;
        enable     = 1'b1;
        digits_bcd = 16'h4321;
        dp_in      = 4'b0000;

        // Held in reset: pins at reset values, no frame_start.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_hold", BLANK);

        // Release and scan every table vector frame by frame.
        rst = 1'b1;
        for (int r = 0; r < 7; r++) begin
            digits_bcd = vecs[r].digits;
            dp_in      = vecs[r].dpi;
            run_frame($sformatf("vec%0d", r), vecs[r]);
        end

        // Disable in the middle of digit 1's SHOW phase.
        for (int k = 0; k < 15; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("pre_disable_show", {4'b1101, G5, 1'b1, 1'b0});
        enable = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("disabled k%0d", k), BLANK);
        end
        enable = 1'b1;
        run_frame("reenable", vecs[6]);

        // Asynchronous reset between edges while digit 0 is shown.
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("pre_reset_show", {4'b1110, G0, 1'b1, 1'b0});
        #2;
        rst = 1'b0;
        #1;
        check("async_reset_immediate", BLANK);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("reset_held k%0d", k), BLANK);
        end
        rst = 1'b1;
        run_frame("after_reset", vecs[6]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
